// File: rtl/dps_bus_master_if.sv
// Port bundle for the DPS bus master: core load/store, DPS request/response and IRQ signals.
// Latency: none, wires only.
// Backpressure: iDPS_BUSY stalls the DPS request; the core waits while oCORE_BUSY is high.
interface dps_bus_master_if;
   logic        iCORE_REQ;
   logic        oCORE_BUSY;
   logic        iCORE_RW;
   logic [31:0] iCORE_ADDR;
   logic [31:0] iCORE_DATA;
   logic        oCORE_VALID;
   logic        oCORE_ERR;
   logic [31:0] oCORE_DATA;
   logic        oDPS_REQ;
   logic        iDPS_BUSY;
   logic        oDPS_RW;
   logic [31:0] oDPS_ADDR;
   logic [31:0] oDPS_DATA;
   logic        iDPS_VALID;
   logic [31:0] iDPS_DATA;
   logic        iDPS_IRQ_REQ;
   logic [5:0]  iDPS_IRQ_NUM;
   logic        oDPS_IRQ_ACK;
   logic        oCORE_IRQ_VALID;
   logic [5:0]  oCORE_IRQ_NUM;
   logic        iCORE_IRQ_ACK;

   modport master (
      input  iCORE_REQ, iCORE_RW, iCORE_ADDR, iCORE_DATA,
      output oCORE_BUSY, oCORE_VALID, oCORE_ERR, oCORE_DATA,
      output oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA,
      input  iDPS_BUSY, iDPS_VALID, iDPS_DATA,
      input  iDPS_IRQ_REQ, iDPS_IRQ_NUM, iCORE_IRQ_ACK,
      output oDPS_IRQ_ACK, oCORE_IRQ_VALID, oCORE_IRQ_NUM
   );

   modport slave (
      output iCORE_REQ, iCORE_RW, iCORE_ADDR, iCORE_DATA,
      input  oCORE_BUSY, oCORE_VALID, oCORE_ERR, oCORE_DATA,
      input  oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA,
      output iDPS_BUSY, iDPS_VALID, iDPS_DATA,
      output iDPS_IRQ_REQ, iDPS_IRQ_NUM, iCORE_IRQ_ACK,
      input  oDPS_IRQ_ACK, oCORE_IRQ_VALID, oCORE_IRQ_NUM
   );
endinterface

// File: rtl/dps_bus_master.sv
// Core-side DPS bus initiator: one load/store at a time, address decode, IRQ pending holder.
// Latency: read 4 cycles, write 3 cycles (DPS idle, 1-cycle read response); decode error 2.
// Backpressure: request held while iDPS_BUSY; access aborted with error after TIMEOUT_CYCLES.
module dps_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic               iCLOCK,
   input  logic               inRESET,
   dps_bus_master_if.master   bus
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_RD_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;

   logic [1:0]  state;
   logic [7:0]  tmo_cnt;
   logic [8:0]  cnt_inc;
   logic        tmo_hit;
   logic        legal;
   logic        resp_err;
   logic [31:0] rd_data;

   // Address map decode of the incoming core request; 0x120 is read-only.
   always_comb begin
      legal = 1'b0;
      if (bus.iCORE_ADDR[1:0] == 2'b00) begin
         if (bus.iCORE_ADDR <= 32'h74 || bus.iCORE_ADDR == 32'h100 ||
             bus.iCORE_ADDR == 32'h104 || bus.iCORE_ADDR == 32'h108 ||
             (bus.iCORE_ADDR == 32'h120 && !bus.iCORE_RW))
            legal = 1'b1;
      end
   end

   // The counter value after this cycle; >= so a read accepted on the last allowed
   // cycle still times out on its first RD_WAIT cycle.
   assign cnt_inc = {1'b0, tmo_cnt} + 9'd1;
   assign tmo_hit = (cnt_inc >= 9'(TIMEOUT_CYCLES));

   assign bus.oCORE_BUSY = (state != ST_IDLE);

   // Access FSM: latch request, drive DPS handshake, wait for data, report completion.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state           <= ST_IDLE;
         tmo_cnt         <= 8'd0;
         resp_err        <= 1'b0;
         rd_data         <= 32'd0;
         bus.oCORE_VALID <= 1'b0;
         bus.oCORE_ERR   <= 1'b0;
         bus.oCORE_DATA  <= 32'd0;
         bus.oDPS_REQ    <= 1'b0;
         bus.oDPS_RW     <= 1'b0;
         bus.oDPS_ADDR   <= 32'd0;
         bus.oDPS_DATA   <= 32'd0;
      end else begin
         bus.oCORE_VALID <= 1'b0;
         bus.oCORE_ERR   <= 1'b0;
         bus.oCORE_DATA  <= 32'd0;
         case (state)
            ST_IDLE: begin
               if (bus.iCORE_REQ) begin
                  bus.oDPS_RW   <= bus.iCORE_RW;
                  bus.oDPS_ADDR <= bus.iCORE_ADDR;
                  bus.oDPS_DATA <= bus.iCORE_DATA;
                  if (legal) begin
                     resp_err     <= 1'b0;
                     bus.oDPS_REQ <= 1'b1;
                     state        <= ST_ISSUE;
                  end else begin
                     resp_err <= 1'b1;
                     state    <= ST_RESP;
                  end
               end
            end
            ST_ISSUE: begin
               tmo_cnt <= cnt_inc[7:0];
               if (!bus.iDPS_BUSY) begin
                  bus.oDPS_REQ <= 1'b0;
                  state        <= bus.oDPS_RW ? ST_RESP : ST_RD_WAIT;
               end else if (tmo_hit) begin
                  bus.oDPS_REQ <= 1'b0;
                  resp_err     <= 1'b1;
                  state        <= ST_RESP;
               end
            end
            ST_RD_WAIT: begin
               tmo_cnt <= cnt_inc[7:0];
               if (bus.iDPS_VALID) begin
                  rd_data <= bus.iDPS_DATA;
                  state   <= ST_RESP;
               end else if (tmo_hit) begin
                  resp_err <= 1'b1;
                  state    <= ST_RESP;
               end
            end
            default: begin
               tmo_cnt         <= 8'd0;
               bus.oCORE_VALID <= 1'b1;
               bus.oCORE_ERR   <= resp_err;
               bus.oCORE_DATA  <= resp_err ? 32'hFFFF_FFFF : (bus.oDPS_RW ? 32'd0 : rd_data);
               state           <= ST_IDLE;
            end
         endcase
      end
   end

   // IRQ holder: capture one DPS interrupt, ack it once, keep it until the core consumes it.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         bus.oDPS_IRQ_ACK    <= 1'b0;
         bus.oCORE_IRQ_VALID <= 1'b0;
         bus.oCORE_IRQ_NUM   <= 6'd0;
      end else begin
         bus.oDPS_IRQ_ACK <= 1'b0;
         if (bus.oCORE_IRQ_VALID) begin
            if (bus.iCORE_IRQ_ACK)
               bus.oCORE_IRQ_VALID <= 1'b0;
         end else if (bus.iDPS_IRQ_REQ && !bus.oDPS_IRQ_ACK) begin
            bus.oCORE_IRQ_VALID <= 1'b1;
            bus.oCORE_IRQ_NUM   <= bus.iDPS_IRQ_NUM;
            bus.oDPS_IRQ_ACK    <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_dps_bus_master.sv
// Bench for dps_bus_master: directed accesses and IRQ sequences against a transaction model.
// Latency: the model predicts completion cycles from issue cycle, DPS busy span and response delay.
// Backpressure: DPS busy and response timing are scheduled per vector.
`timescale 1ns/1ps
module tb_dps_bus_master;
   localparam int TO   = 8;
   localparam int NCYC = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   dps_bus_master_if bus();

   dps_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
      .iCLOCK  (clk),
      .inRESET (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Cycle index: cycle c is the interval that starts at the c-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   bit          e_valid [NCYC];
   bit          e_err   [NCYC];
   logic [31:0] e_data  [NCYC];
   bit          e_busy  [NCYC];
   bit          e_req   [NCYC];
   bit          e_iack  [NCYC];
   bit          e_ivld  [NCYC];
   logic [5:0]  e_inum  [NCYC];
   bit          f_rw;
   logic [31:0] f_addr, f_data;

   int n_chk = 0;
   int n_fail = 0;
   bit en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NCYC; i++) begin
         e_valid[i] = 0; e_err[i] = 0; e_data[i] = 32'd0; e_busy[i] = 0;
         e_req[i] = 0; e_iack[i] = 0; e_ivld[i] = 0; e_inum[i] = 6'd0;
      end
   endtask

   // Transaction-level expectation: request issued in cycle t, DPS busy for b cycles of the
   // request, read data d cycles after acceptance (d=0: never). Event index k counts cycles
   // from t+1; completion is reported two cycles after the deciding event.
   task automatic model_access(input int t, input bit rw, input logic [31:0] addr,
                               input logic [31:0] wd, input int b, input int d,
                               input logic [31:0] rd);
      bit legal, err;
      int k, ev, done, last_req;
      logic [31:0] dat;
      legal = (addr % 4 == 0) &&
              (addr <= 32'h74 || addr inside {32'h100, 32'h104, 32'h108} ||
               (addr == 32'h120 && !rw));
      f_rw = rw; f_addr = addr; f_data = wd;
      err = 1'b1;
      if (!legal) begin
         done = t + 2;
      end else begin
         ev = rw ? b + 1 : (d > 0 ? b + 1 + d : 1000);
         if (ev <= TO) begin k = ev; err = 1'b0; end
         else k = TO;
         last_req = (b + 1 < k) ? b + 1 : k;
         for (int i = 1; i <= last_req; i++) e_req[t + i] = 1;
         done = t + k + 2;
      end
      dat = err ? 32'hFFFF_FFFF : (rw ? 32'd0 : rd);
      for (int i = t + 1; i < done; i++) e_busy[i] = 1;
      e_valid[done] = 1; e_err[done] = err; e_data[done] = dat;
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (en && cyc < NCYC) begin
         check("core_valid", 32'(bus.oCORE_VALID), 32'(e_valid[cyc]));
         if (e_valid[cyc]) begin
            check("core_err", 32'(bus.oCORE_ERR), 32'(e_err[cyc]));
            check("core_data", bus.oCORE_DATA, e_data[cyc]);
         end
         check("core_busy", 32'(bus.oCORE_BUSY), 32'(e_busy[cyc]));
         check("dps_req", 32'(bus.oDPS_REQ), 32'(e_req[cyc]));
         if (e_req[cyc]) begin
            check("dps_rw", 32'(bus.oDPS_RW), 32'(f_rw));
            check("dps_addr", bus.oDPS_ADDR, f_addr);
            check("dps_data", bus.oDPS_DATA, f_data);
         end
         check("irq_ack", 32'(bus.oDPS_IRQ_ACK), 32'(e_iack[cyc]));
         check("irq_valid", 32'(bus.oCORE_IRQ_VALID), 32'(e_ivld[cyc]));
         if (e_ivld[cyc]) check("irq_num", 32'(bus.oCORE_IRQ_NUM), 32'(e_inum[cyc]));
      end
   end

   // Drive one access (entered just after a rising edge) and pin its outcome to literals.
   task automatic access(input string nm, input bit rw, input logic [31:0] addr,
                         input logic [31:0] wd, input int b, input int d,
                         input logic [31:0] rd, input int late, input int exp_lat,
                         input bit exp_err, input logic [31:0] exp_dat);
      int t, got, i;
      logic [31:0] gdat;
      bit gerr;
      t = cyc;
      model_access(t, rw, addr, wd, b, d, rd);
      bus.iCORE_REQ = 1'b1; bus.iCORE_RW = rw; bus.iCORE_ADDR = addr; bus.iCORE_DATA = wd;
      got = -1; i = 0; gdat = 32'd0; gerr = 1'b0;
      while (i < 40 && (got < 0 || i <= got || i <= late)) begin
         @(posedge clk); #1;
         i++;
         bus.iCORE_REQ  = 1'b0;
         bus.iDPS_BUSY  = (i <= b);
         bus.iDPS_VALID = (d > 0 && i == b + 1 + d) || (late > 0 && i == late);
         bus.iDPS_DATA  = (d > 0 && i == b + 1 + d) ? rd :
                          ((late > 0 && i == late) ? 32'hBAD0_BAD0 : 32'd0);
         if (bus.oCORE_VALID && got < 0) begin
            got = i; gdat = bus.oCORE_DATA; gerr = bus.oCORE_ERR;
         end
      end
      bus.iDPS_BUSY = 1'b0; bus.iDPS_VALID = 1'b0; bus.iDPS_DATA = 32'd0;
      check({nm, "_latency"}, 32'(got), 32'(exp_lat));
      check({nm, "_err"}, 32'(gerr), 32'(exp_err));
      check({nm, "_data"}, gdat, exp_dat);
   endtask

   // Two back-to-back DPS interrupts; the second waits for the core to consume the first.
   task automatic irq_seq();
      int t0;
      t0 = cyc;
      e_iack[t0 + 1] = 1;
      for (int c = t0 + 1; c <= t0 + 6; c++) begin e_ivld[c] = 1; e_inum[c] = 6'h36; end
      e_iack[t0 + 8] = 1;
      for (int c = t0 + 8; c <= t0 + 11; c++) begin e_ivld[c] = 1; e_inum[c] = 6'h37; end
      bus.iDPS_IRQ_REQ = 1'b1; bus.iDPS_IRQ_NUM = 6'h36;
      for (int i = 1; i <= 15; i++) begin
         @(posedge clk); #1;
         case (i)
            1: begin
               check("irq_first_ack", 32'(bus.oDPS_IRQ_ACK), 32'd1);
               check("irq_first_num", 32'(bus.oCORE_IRQ_NUM), 32'h36);
            end
            2: begin
               bus.iDPS_IRQ_REQ = 1'b0;
               check("irq_ack_single", 32'(bus.oDPS_IRQ_ACK), 32'd0);
            end
            3: begin bus.iDPS_IRQ_REQ = 1'b1; bus.iDPS_IRQ_NUM = 6'h37; end
            6: bus.iCORE_IRQ_ACK = 1'b1;
            7: begin
               bus.iCORE_IRQ_ACK = 1'b0;
               check("irq_gap_valid", 32'(bus.oCORE_IRQ_VALID), 32'd0);
            end
            8: check("irq_second_num", 32'(bus.oCORE_IRQ_NUM), 32'h37);
            9: bus.iDPS_IRQ_REQ = 1'b0;
            11: bus.iCORE_IRQ_ACK = 1'b1;
            12: bus.iCORE_IRQ_ACK = 1'b0;
            13: bus.iCORE_IRQ_ACK = 1'b1;
            14: bus.iCORE_IRQ_ACK = 1'b0;
            default: ;
         endcase
      end
   endtask

   // Reset in the middle of a read: outputs clear immediately, the access never completes.
   task automatic reset_mid_read();
      int t;
      t = cyc;
      model_access(t, 1'b0, 32'h4, 32'd0, 0, 0, 32'd0);
      bus.iCORE_REQ = 1'b1; bus.iCORE_RW = 1'b0; bus.iCORE_ADDR = 32'h4; bus.iCORE_DATA = 32'd0;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         bus.iCORE_REQ = 1'b0;
      end
      check("rd_wait_busy", 32'(bus.oCORE_BUSY), 32'd1);
      #2;
      en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(bus.oCORE_BUSY), 32'd0);
      check("rst_dps_addr", bus.oDPS_ADDR, 32'd0);
      check("rst_valid", 32'(bus.oCORE_VALID), 32'd0);
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      en = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.iCORE_REQ = 1'b0; bus.iCORE_RW = 1'b0; bus.iCORE_ADDR = 32'd0; bus.iCORE_DATA = 32'd0;
      bus.iDPS_BUSY = 1'b0; bus.iDPS_VALID = 1'b0; bus.iDPS_DATA = 32'd0;
      bus.iDPS_IRQ_REQ = 1'b0; bus.iDPS_IRQ_NUM = 6'd0; bus.iCORE_IRQ_ACK = 1'b0;
      #3;
      check("reset_busy", 32'(bus.oCORE_BUSY), 32'd0);
      check("reset_valid", 32'(bus.oCORE_VALID), 32'd0);
      check("reset_dps_req", 32'(bus.oDPS_REQ), 32'd0);
      check("reset_irq_valid", 32'(bus.oCORE_IRQ_VALID), 32'd0);
      check("reset_irq_ack", 32'(bus.oDPS_IRQ_ACK), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_model();
      en = 1'b1;
      @(posedge clk); #1;

      //     name          rw    addr          wdata         b  d  rdata         late lat err data
      access("rd_104",     1'b0, 32'h104,      32'd0,        0, 1, 32'h5A,       0,   4,  0, 32'h5A);
      access("wr_010",     1'b1, 32'h10,       32'h0000_A5A5,3, 0, 32'd0,        0,   6,  0, 32'd0);
      access("rd_080",     1'b0, 32'h80,       32'd0,        0, 1, 32'h1,        0,   2,  1, 32'hFFFF_FFFF);
      access("wr_120",     1'b1, 32'h120,      32'h1234,     0, 0, 32'd0,        0,   2,  1, 32'hFFFF_FFFF);
      access("rd_tmo",     1'b0, 32'h0,        32'd0,        0, 0, 32'd0,        11,  10, 1, 32'hFFFF_FFFF);
      access("rd_120",     1'b0, 32'h120,      32'd0,        1, 2, 32'h1234_5678,0,   6,  0, 32'h1234_5678);
      access("wr_074",     1'b1, 32'h74,       32'hFFFF_0000,0, 0, 32'd0,        0,   3,  0, 32'd0);
      access("rd_misal",   1'b0, 32'h102,      32'd0,        0, 1, 32'h7,        0,   2,  1, 32'hFFFF_FFFF);
      access("rd_edge",    1'b0, 32'h8,        32'd0,        2, 5, 32'h0BAD_CAFE,0,   10, 0, 32'h0BAD_CAFE);
      access("wr_tmo",     1'b1, 32'h108,      32'h55,       9, 0, 32'd0,        0,   10, 1, 32'hFFFF_FFFF);

      reset_mid_read();
      access("rd_post_rst",1'b0, 32'h108,      32'd0,        0, 1, 32'hCAFE_F00D,0,   4,  0, 32'hCAFE_F00D);

      fork
         irq_seq();
         access("rd_with_irq", 1'b0, 32'h40, 32'd0, 1, 1, 32'h0000_4040, 0, 5, 0, 32'h0000_4040);
      join

      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
